// File: rtl/tx_arb_pkg.sv
// Shared types and defaults for the trace/status UART transmit arbiter.
package tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACE = 2'd1,
        ST_STAT  = 2'd2
    } arb_state_e;

    localparam int unsigned FRAME_LEN_DEF = 16;
    localparam int unsigned MAX_HOLD_DEF  = 4;
    localparam int unsigned HOLD_W        = 4;

endpackage

// File: rtl/tx_arbiter.sv
// Arbitrates trace frames and status messages onto one UART byte stream.
// Status arbitration is built only when TX_ARB_STAT_EN is defined.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned MAX_HOLD  = MAX_HOLD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       traceAvail,
    input  logic [7:0] traceVal,
    output logic       traceNext,
    input  logic       statAvail,
    input  logic [7:0] statVal,
    input  logic       statLast,
    output logic       statNext,
    input  logic       txFree,
    output logic [7:0] txByte,
    output logic       txStrobe,
    output logic       statGrant
);

    localparam int unsigned      CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       txByte_q, txByte_d;
    logic             txStrobe_q, txStrobe_d;
    logic             traceNext_q, traceNext_d;
    logic             trace_xfer;

    // A pending strobe blocks the next transfer, giving at most one byte per two cycles.
    assign trace_xfer = traceAvail && txFree && !txStrobe_q && !traceNext_q;

`ifdef TX_ARB_STAT_EN
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              statNext_q, statNext_d;
    logic              stat_xfer;

    assign stat_xfer = statAvail && txFree && !txStrobe_q && !statNext_q;
`else
    logic unused_stat;
    assign unused_stat = ^{statAvail, statVal, statLast};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        txByte_d    = txByte_q;
        txStrobe_d  = 1'b0;
        traceNext_d = 1'b0;
`ifdef TX_ARB_STAT_EN
        hold_d      = hold_q;
        statNext_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef TX_ARB_STAT_EN
                if (statAvail && ((hold_q >= HOLD_LIM) || !traceAvail)) begin
                    state_d = ST_STAT;
                    hold_d  = '0;
                end else if (traceAvail) begin
                    state_d = ST_TRACE;
                end
`else
                if (traceAvail) begin
                    state_d = ST_TRACE;
                end
`endif
            end
            ST_TRACE: begin
                if (trace_xfer) begin
                    txByte_d    = traceVal;
                    txStrobe_d  = 1'b1;
                    traceNext_d = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
`ifdef TX_ARB_STAT_EN
                        // Frames completed while status waits push it toward a forced grant.
                        if (statAvail && (hold_q != HOLD_SAT)) begin
                            hold_d = hold_q + 1'b1;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_STAT: begin
`ifdef TX_ARB_STAT_EN
                if (stat_xfer) begin
                    txByte_d   = statVal;
                    txStrobe_d = 1'b1;
                    statNext_d = 1'b1;
                    if (statLast) begin
                        state_d = ST_IDLE;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            txByte_q    <= '0;
            txStrobe_q  <= 1'b0;
            traceNext_q <= 1'b0;
`ifdef TX_ARB_STAT_EN
            hold_q      <= '0;
            statNext_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            txByte_q    <= txByte_d;
            txStrobe_q  <= txStrobe_d;
            traceNext_q <= traceNext_d;
`ifdef TX_ARB_STAT_EN
            hold_q      <= hold_d;
            statNext_q  <= statNext_d;
`endif
        end
    end

    assign txByte    = txByte_q;
    assign txStrobe  = txStrobe_q;
    assign traceNext = traceNext_q;
`ifdef TX_ARB_STAT_EN
    assign statNext  = statNext_q;
    assign statGrant = (state_q == ST_STAT);
`else
    assign statNext  = 1'b0;
    assign statGrant = 1'b0;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: cycle table, directed sequences and
// randomized sources checked by a queue scoreboard plus framing rules.
module tb_tx_arbiter;

    localparam int unsigned FL = 16;
    localparam int unsigned MH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       traceAvail = 1'b0, statAvail = 1'b0, statLast = 1'b0, txFree = 1'b0;
    logic [7:0] traceVal = 8'h00, statVal = 8'h00;
    logic       traceNext, statNext, txStrobe, statGrant;
    logic [7:0] txByte;

    int checks   = 0;
    int failures = 0;

    tx_arbiter #(.FRAME_LEN(FL), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst),
        .traceAvail(traceAvail), .traceVal(traceVal), .traceNext(traceNext),
        .statAvail(statAvail), .statVal(statVal), .statLast(statLast), .statNext(statNext),
        .txFree(txFree), .txByte(txByte), .txStrobe(txStrobe), .statGrant(statGrant)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] v; logic last; } sbyte_t;
    typedef struct { int cyc; bit isStat; logic [7:0] b; } ev_t;
    typedef struct {
        bit rst; bit ta; logic [7:0] tv; bit fr;
        bit es; bit en; logic [7:0] eb;
    } vec_t;

    logic [7:0] tq[$];
    sbyte_t     sq[$];
    ev_t        evlog[$];
    int         cyc = 0, gcnt = 0, tcnt = 0;
    bit         inMsg = 0, prevStrobe = 0;
    bit         tgate = 0, sgate = 0, rstReq = 1, randFree = 0, freeVal = 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int pend_stat();
`ifdef TX_ARB_STAT_EN
        return sq.size();
`else
        return 0;
`endif
    endfunction

    // Observe outputs of the previous edge and retire consumed source bytes.
    task automatic step();
        ev_t e;
        @(negedge clk);
        cyc++;
        if (statGrant) gcnt++;
`ifndef TX_ARB_STAT_EN
        if (statAvail) chk("stat_disabled", {statGrant, statNext}, 0);
`endif
        if (txStrobe || traceNext || statNext)
            chk("strobe_next_align", {txStrobe, traceNext | statNext, traceNext & statNext}, 3'b110);
        if (txStrobe) begin
            chk("min_spacing", prevStrobe, 0);
            chk("txfree_honoured", txFree, 1);
        end
        if (traceNext) begin
            if (tq.size() == 0) chk("trace_spurious", 1, 0);
            else begin
                chk("trace_byte", txByte, tq[0]);
`ifdef TX_ARB_STAT_EN
                chk("msg_unsplit", inMsg, 0);
`endif
                tq.pop_front();
                tcnt = (tcnt + 1) % FL;
                e = '{cyc, 1'b0, txByte};
                evlog.push_back(e);
            end
        end
        if (statNext) begin
            if (sq.size() == 0) chk("stat_spurious", 1, 0);
            else begin
                chk("stat_byte", txByte, sq[0].v);
                chk("frame_unsplit", tcnt, 0);
                inMsg = !sq[0].last;
                sq.pop_front();
                e = '{cyc, 1'b1, txByte};
                evlog.push_back(e);
            end
        end
        prevStrobe = txStrobe;
    endtask

    task automatic drive();
        rst        = rstReq;
        traceAvail = tgate && (tq.size() > 0);
        traceVal   = (tq.size() > 0) ? tq[0] : 8'h00;
        statAvail  = sgate && (sq.size() > 0);
        statVal    = (sq.size() > 0) ? sq[0].v : 8'h00;
        statLast   = (sq.size() > 0) ? sq[0].last : 1'b0;
        txFree     = randFree ? ($urandom_range(0, 3) != 0) : freeVal;
        if (rstReq) begin
            tcnt = 0; inMsg = 0; prevStrobe = 0;
        end
    endtask

    task automatic tick();
        step();
        drive();
    endtask

    task automatic reset_dut();
        tq.delete(); sq.delete();
        tgate = 1; sgate = 1; randFree = 0; freeVal = 1; rstReq = 1;
        tick();
        step();
        chk("rst_txStrobe", txStrobe, 0);
        chk("rst_nexts", {traceNext, statNext}, 0);
        chk("rst_statGrant", statGrant, 0);
        chk("rst_txByte", txByte, 0);
        rstReq = 0;
        drive();
        evlog.delete();
        gcnt = 0;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while ((tq.size() > 0 || pend_stat() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk(name, tq.size() + pend_stat(), 0);
    endtask

    initial begin
        vec_t tbl[13];
        int   n, stall, nt, ns, nsExp;
        bit   done;
        sbyte_t s;

        // Cycle table from reset: handshake latency, txFree stall, mid-frame gap, txByte hold, reset.
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11};
        tbl[3]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h11};
        tbl[4]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h11};
        tbl[5]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22};
        tbl[6]  = '{1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 8'h22};
        tbl[7]  = '{1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 8'h22};
        tbl[8]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33};
        tbl[9]  = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[11] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h44};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h44};
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; traceAvail = tbl[i].ta; traceVal = tbl[i].tv;
            txFree = tbl[i].fr; statAvail = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_txStrobe", i), txStrobe, tbl[i].es);
            chk($sformatf("vec%0d_traceNext", i), traceNext, tbl[i].en);
            chk($sformatf("vec%0d_txByte", i), txByte, tbl[i].eb);
            chk($sformatf("vec%0d_stat", i), {statGrant, statNext}, 0);
        end

        // 32 trace bytes back to back: in order, exactly two cycles apart.
        reset_dut();
        for (int i = 0; i < 32; i++) tq.push_back(8'(i));
        drain(200, "t033_timeout");
        chk("t033_count", evlog.size(), 32);
        for (int i = 0; i < evlog.size(); i++) begin
            chk($sformatf("t033_byte%0d", i), evlog[i].b, i);
            if (i > 0) chk($sformatf("t033_gap%0d", i), evlog[i].cyc - evlog[i-1].cyc, 2);
        end
        chk("t033_grant_cycles", gcnt, 0);

        // txFree low for 10 cycles after the 6th byte of a frame.
        reset_dut();
        for (int i = 0; i < 20; i++) tq.push_back(8'(8'h40 + i));
        n = 0;
        while (evlog.size() < 6 && n < 100) begin
            step();
            if (evlog.size() >= 6) freeVal = 0;
            drive();
            n++;
        end
        stall = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (txStrobe || traceNext || statNext) stall++;
            if (i == 9) freeVal = 1;
            drive();
        end
        chk("t037_stall_strobes", stall, 0);
        drain(200, "t037_timeout");
        chk("t037_count", evlog.size(), 20);
        for (int i = 0; i < evlog.size(); i++)
            chk($sformatf("t037_byte%0d", i), evlog[i].b, 8'h40 + i);

        // Reset right after the 7th byte; the frame restarts from byte count 0.
        reset_dut();
        for (int i = 0; i < 23; i++) tq.push_back(8'(8'h80 + i));
        done = 0; n = 0;
        while ((tq.size() > 0 || pend_stat() > 0) && n < 300) begin
            step();
            if (evlog.size() == 7 && !done) begin
                done = 1; rstReq = 1;
                drive();
                step();
                chk("t038_txStrobe", txStrobe, 0);
                chk("t038_nexts", {traceNext, statNext}, 0);
                chk("t038_statGrant", statGrant, 0);
                chk("t038_txByte", txByte, 0);
                rstReq = 0;
`ifdef TX_ARB_STAT_EN
                s = '{8'h5A, 1'b1};
                sq.push_back(s);
`endif
            end
            drive();
            n++;
        end
        chk("t038_reset_hit", done, 1);
        chk("t038_timeout", tq.size() + pend_stat(), 0);
`ifdef TX_ARB_STAT_EN
        chk("t038_count", evlog.size(), 24);
        if (evlog.size() == 24) chk("t038_stat_after_frame", {evlog[23].isStat, evlog[23].b}, {1'b1, 8'h5A});
`else
        chk("t038_count", evlog.size(), 23);
`endif
        for (int i = 0; i < evlog.size() && i < 23; i++)
            chk($sformatf("t038_byte%0d", i), evlog[i].b, 8'h80 + i);

`ifdef TX_ARB_STAT_EN
        // Three-byte status message with trace idle.
        reset_dut();
        s = '{8'hA1, 1'b0}; sq.push_back(s);
        s = '{8'hA2, 1'b0}; sq.push_back(s);
        s = '{8'hA3, 1'b1}; sq.push_back(s);
        drain(100, "t034_timeout");
        chk("t034_count", evlog.size(), 3);
        for (int i = 0; i < evlog.size(); i++)
            chk($sformatf("t034_byte%0d", i), {evlog[i].isStat, evlog[i].b}, {1'b1, 8'hA1 + 8'(i)});
        // Grant spans entry through the cycle before the last byte's strobe: 2*3-1 cycles.
        chk("t034_grant_cycles", gcnt, 5);
        chk("t034_grant_released", statGrant, 0);

        // Both sources saturated: MAX_HOLD frames, then the status message, then trace.
        reset_dut();
        for (int i = 0; i < 80; i++) tq.push_back(8'(i));
        s = '{8'hC0, 1'b0}; sq.push_back(s);
        s = '{8'hC1, 1'b0}; sq.push_back(s);
        s = '{8'hC2, 1'b1}; sq.push_back(s);
        drain(500, "t035_timeout");
        chk("t035_count", evlog.size(), 83);
        for (int i = 0; i < evlog.size(); i++)
            chk($sformatf("t035_kind%0d", i), evlog[i].isStat, (i >= MH * FL && i < MH * FL + 3) ? 1 : 0);

        // Trace stalls after byte 5 with status pending: status still waits for the frame.
        reset_dut();
        for (int i = 0; i < 16; i++) tq.push_back(8'(8'h10 + i));
        s = '{8'hE0, 1'b0}; sq.push_back(s);
        s = '{8'hE1, 1'b1}; sq.push_back(s);
        n = 0;
        while (evlog.size() < 5 && n < 100) begin tick(); n++; end
        tgate = 0;
        for (int i = 0; i < 12; i++) tick();
        chk("t036_no_bytes_in_gap", evlog.size(), 5);
        tgate = 1;
        drain(200, "t036_timeout");
        chk("t036_count", evlog.size(), 18);
        for (int i = 0; i < evlog.size(); i++)
            chk($sformatf("t036_kind%0d", i), evlog[i].isStat, (i >= 16) ? 1 : 0);
`endif

        // Randomized sources and txFree, checked by scoreboard and framing rules.
        reset_dut();
        randFree = 1;
        for (int i = 0; i < 6 * FL; i++) tq.push_back(8'($urandom));
        nsExp = 0;
        for (int m = 0; m < 8; m++) begin
            int len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                s = '{8'($urandom), (k == len - 1)};
                sq.push_back(s);
                nsExp++;
            end
        end
        n = 0;
        while ((tq.size() > 0 || pend_stat() > 0) && n < 4000) begin
            tgate = ($urandom_range(0, 3) != 0);
            sgate = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        chk("rand_timeout", tq.size() + pend_stat(), 0);
        nt = 0; ns = 0;
        foreach (evlog[i]) if (evlog[i].isStat) ns++; else nt++;
        chk("rand_trace_count", nt, 6 * FL);
`ifdef TX_ARB_STAT_EN
        chk("rand_stat_count", ns, nsExp);
`else
        chk("rand_stat_count", ns, 0);
        chk("rand_stat_untouched", sq.size(), nsExp);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
